// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM that sequences the shared multicycle MIPS
// datapath (one memory port, one ALU, IR and A/B/ALUOut holding registers).
// Handles the req/ready handshake to the unified memory.
// Optional feature: define MC_BNE_EN to decode bne (op 000101) as a branch
// taken on ~zero; without it op 000101 is an illegal instruction.
module multicycle_controller #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_ctrl_sig,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

  state_t     state;
  logic [2:0] fn_alu;
  logic       fn_ok;
  logic       br_take;

  // R-type funct decode; unknown functs fall back to add and are flagged.
  always_comb begin
    fn_alu = 3'b010;
    fn_ok  = 1'b1;
    case (funct)
      FN_ADD:  fn_alu = 3'b010;
      FN_SUB:  fn_alu = 3'b110;
      FN_AND:  fn_alu = 3'b000;
      FN_OR:   fn_alu = 3'b001;
      FN_SLT:  fn_alu = 3'b111;
      default: fn_ok  = 1'b0;
    endcase
  end

  // Branch condition; op stays valid in BRANCH because IR holds it.
  always_comb begin
`ifdef MC_BNE_EN
    br_take = (op == OP_BNE) ? ~zero : zero;
`else
    br_take = zero;
`endif
  end

  // State register and next-state sequencing; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       state <= BRANCH;
`endif
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) state <= MEMWB;
        MEMWB:   state <= FETCH;
        MEMWR:   if (mem_ready) state <= FETCH;
        EXECUTE: state <= fn_ok ? ALUWB : FETCH;
        ALUWB:   state <= FETCH;
        BRANCH:  state <= FETCH;
        ADDIEX:  state <= ADDIWB;
        ADDIWB:  state <= FETCH;
        JUMP:    state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Per-state control strobes; everything is forced low while reset is high.
  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctrl_sig = 3'b000;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    illegal_op   = 1'b0;
    state_dbg    = '0;
    if (!reset) begin
      state_dbg = STATE_W'(state);
      case (state)
        FETCH: begin
          mem_req      = 1'b1;
          alu_src_b    = 2'b01;
          alu_ctrl_sig = 3'b010;
          ir_write     = mem_ready;
          pc_en        = mem_ready;
        end
        DECODE: begin
          alu_src_b    = 2'b11;
          alu_ctrl_sig = 3'b010;
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_BNE_EN
            OP_BNE:  illegal_op = 1'b0;
`endif
            default: illegal_op = 1'b1;
          endcase
        end
        MEMADR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_ctrl_sig = 3'b010;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        EXECUTE: begin
          alu_src_a    = 1'b1;
          alu_ctrl_sig = fn_alu;
          illegal_op   = ~fn_ok;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a    = 1'b1;
          alu_ctrl_sig = 3'b110;
          pc_src       = 2'b01;
          pc_en        = br_take;
        end
        ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_ctrl_sig = 3'b010;
        end
        ADDIWB: reg_write = 1'b1;
        JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
